// File: rtl/int_mul_pkg.sv
// Shared constants and helpers for the iterative integer multiplier.
package int_mul_pkg;

    localparam int DEFAULT_WIDTH = 24;

    // The counter is one bit wider than needed so it can reach WIDTH-1 for any legal WIDTH.
    function automatic int cnt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/int_mul.sv
// Iterative radix-2 unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH product over WIDTH cycles,
// with a start/valid handshake.
module int_mul
    import int_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o,
    output logic               valid_o,
    output logic               busy_o
);

    localparam int CW = cnt_bits(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_e;

    mul_state_e state, state_next;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   addend;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_iter;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy_o     = 1'b0;
        valid_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                busy_o = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (start_i) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // acc[WIDTH] is always zero after a shift, so adding the full acc equals adding its low WIDTH bits.
    assign addend    = mplier[0] ? {1'b0, mcand} : '0;
    assign sum       = acc + addend;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p_o    <= '0;
        end else if (accept) begin
            mcand  <= a_i;
            mplier <= b_i;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= {1'b0, sum[WIDTH:1]};
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
            // Latch the final shifted value so p_o holds through IDLE and the next CALC.
            if (last_iter) begin
                p_o <= {sum, mplier[WIDTH-1:1]};
            end
        end
    end

endmodule
